// File: rtl/fir_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_stream_pkg : shared types and defaults for the FIR playback ctrl |
// | Optional FLUSH state built when FIR_STREAM_FLUSH_EN is defined.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fir_stream_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
`ifdef FIR_STREAM_FLUSH_EN
    FLUSH = 3'd4,
`endif
    DONE  = 3'd3
  } state_t;

  // Read stage + fir_din stage + filter latency.
  function automatic int pipe_stages(input int fir_lat);
    return 2 + fir_lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_valid_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_valid_delay : valid-bit shift register covering the filter delay |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fir_valid_delay #(
  parameter int LEN = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  output logic o_cap_en,
  output logic o_valid,
  output logic o_empty_next
);

  logic [LEN-1:0] r_sr;

  // o_cap_en fires one cycle ahead of o_valid so the capture register
  // and the valid bit load on the same edge.
  generate
    if (LEN == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (reset) r_sr <= '0;
        else       r_sr <= i_valid;
      end
      assign o_cap_en     = i_valid;
      assign o_empty_next = 1'b1;
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (reset) r_sr <= '0;
        else       r_sr <= {r_sr[LEN-2:0], i_valid};
      end
      assign o_cap_en     = r_sr[LEN-2];
      assign o_empty_next = (r_sr[LEN-2:0] == '0);
    end
  endgenerate

  assign o_valid = r_sr[LEN-1];

endmodule
`default_nettype wire

// File: rtl/fir_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_stream_ctrl : sample-RAM playback sequencer for the 16-bit FIR   |
// | Optional tail flush: FIR_STREAM_FLUSH_EN.   Revision: 1.0            |
// +----------------------------------------------------------------------+
module fir_stream_ctrl
  import fir_stream_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 100,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int FIR_LAT   = 1,
  parameter int FLUSH_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] fir_din,
  input  logic [DATA_W-1:0] fir_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                c_pipe_stages = pipe_stages(FIR_LAT);
  localparam logic [ADDR_W-1:0] c_depth       = ADDR_W'(DEPTH);

  generate
    if (FIR_LAT < 1 || DEPTH < 1 || (2 ** ADDR_W) < DEPTH || FLUSH_LEN < 1) begin : g_bad_params
      $error("fir_stream_ctrl: illegal parameter set");
    end
  endgenerate

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_len;
  logic              r_err;
  logic              r_rd_vld;
  logic              r_din_vld;
  logic [DATA_W-1:0] r_fir_din;
  logic [DATA_W-1:0] r_out_data;
  logic              w_issue;
  logic              w_last;
  logic              w_accept;
  logic              w_cap_en;
  logic              w_tail_clear;
  logic              w_pipe_empty_nxt;
  logic              w_inject;
  logic              w_rd_zero;

  assign w_last           = (r_addr == r_len - 1'b1);
  assign w_accept         = (r_state == IDLE) && start && (len != '0);
  assign w_pipe_empty_nxt = !r_rd_vld && !r_din_vld && w_tail_clear;

`ifdef FIR_STREAM_FLUSH_EN
  localparam int     c_flush_w   = $clog2(FLUSH_LEN + 1);
  localparam state_t c_after_run = FLUSH;

  logic [c_flush_w-1:0] r_flush_cnt;
  logic                 r_rd_zero;
  logic                 w_flush_last;

  assign w_flush_last = (r_flush_cnt == c_flush_w'(FLUSH_LEN - 1));
  assign w_inject     = (r_state == FLUSH);
  assign w_rd_zero    = r_rd_zero;

  // Flush slots ride the read stage as zero-data reads, so they follow
  // the last real sample without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_cnt <= '0;
      r_rd_zero   <= 1'b0;
    end else begin
      r_flush_cnt <= (r_state == FLUSH) ? r_flush_cnt + 1'b1 : '0;
      r_rd_zero   <= w_inject;
    end
  end
`else
  localparam state_t c_after_run = DRAIN;

  assign w_inject  = 1'b0;
  assign w_rd_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = RUN;
      RUN: begin
        if (stop) begin
          w_state_nxt = DRAIN;
        end else begin
          w_issue = 1'b1;
          if (w_last && !loop_en) w_state_nxt = c_after_run;
        end
      end
`ifdef FIR_STREAM_FLUSH_EN
      FLUSH: if (w_flush_last) w_state_nxt = DRAIN;
`endif
      DRAIN: if (w_pipe_empty_nxt) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_err      <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_din_vld  <= 1'b0;
      r_fir_din  <= '0;
      r_out_data <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        if (len == '0) begin
          r_err <= 1'b1;
        end else begin
          r_err  <= 1'b0;
          r_len  <= (len > c_depth) ? c_depth : len;
          r_addr <= '0;
        end
      end
      if (w_issue) begin
        if (!w_last)      r_addr <= r_addr + 1'b1;
        else if (loop_en) r_addr <= '0;
      end
      r_rd_vld  <= w_issue | w_inject;
      r_din_vld <= r_rd_vld;
      r_fir_din <= (r_rd_vld && !w_rd_zero) ? mem_rdata : '0;
      if (w_cap_en) r_out_data <= fir_dout;
    end
  end

  fir_valid_delay #(
    .LEN (c_pipe_stages - 2)
  ) u_valid_delay (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (r_din_vld),
    .o_cap_en     (w_cap_en),
    .o_valid      (out_valid),
    .o_empty_next (w_tail_clear)
  );

  assign mem_addr = r_addr;
  assign fir_din  = r_fir_din;
  assign out_data = r_out_data;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
`default_nettype none
// Testbench for fir_stream_ctrl: scenario table plus random playbacks
// checked against a cycle-level model of the output stream.
module tb_fir_stream_ctrl;

  localparam int DATA_W    = 16;
  localparam int DEPTH     = 100;
  localparam int ADDR_W    = 8;
  localparam int FIR_LAT   = 1;
  localparam int FLUSH_LEN = 16;
`ifdef FIR_STREAM_FLUSH_EN
  localparam int FLUSH_N = FLUSH_LEN;
`else
  localparam int FLUSH_N = 0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, stop, loop_en;
  logic [ADDR_W-1:0] len, mem_addr;
  logic [DATA_W-1:0] mem_rdata, fir_din, fir_dout, out_data;
  logic              out_valid, busy, done, err;

  fir_stream_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .FIR_LAT(FIR_LAT), .FLUSH_LEN(FLUSH_LEN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .len(len), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .fir_din(fir_din),
    .fir_dout(fir_dout), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) mem_rdata <= ram[mem_addr];
  // Identity filter; with FIR_LAT=1 the single clock is the capture register.
  assign fir_dout = fir_din;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int len;
    int loop_cycles;   // loop_en high for RUN cycles 1..loop_cycles
    int stop_at;       // stop pulse in this cycle after start (0 = none)
    bit drain_start;   // extra start pulse in the first cycle after RUN
    bit ramp;          // RAM[i] = i+1 instead of random
    int exp_n;         // expected outputs without flush (-1 = model only)
    bit exp_err;
    bit exp_done;
  } scn_t;

  logic [DATA_W-1:0] exp_q[$];

  // Expected output stream: one sample per RUN cycle starting at address 0.
  task automatic build_model(input scn_t t, output int run_end, output bit stopped);
    int lim, a;
    lim = (t.len > DEPTH) ? DEPTH : t.len;
    exp_q.delete();
    run_end = 0;
    stopped = 1'b0;
    a = 0;
    if (lim > 0) begin
      for (int r = 1; r < 1000; r++) begin
        if (r == t.stop_at) begin run_end = r; stopped = 1'b1; break; end
        exp_q.push_back(ram[a]);
        if (a == lim - 1 && r > t.loop_cycles) begin run_end = r; break; end
        a = (a == lim - 1) ? 0 : a + 1;
      end
      if (!stopped) repeat (FLUSH_N) exp_q.push_back('0);
    end
  endtask

  task automatic run_scn(input scn_t t);
    logic [DATA_W-1:0] got_d[$];
    int got_c[$];
    int ndone, done_r, busy_cnt, run_end, exp_n, bad_idx, exp_done_r;
    bit stopped;
    ndone = 0; done_r = -1; busy_cnt = 0; bad_idx = -1;
    for (int i = 0; i < (1 << ADDR_W); i++)
      ram[i] = t.ramp ? DATA_W'(i + 1) : DATA_W'($urandom);
    build_model(t, run_end, stopped);
    for (int r = 0; r < 600; r++) begin
      @(posedge clk); #1;
      start   = (r == 0) || (t.drain_start && run_end > 0 && r == run_end + 1);
      stop    = (t.stop_at != 0 && r == t.stop_at);
      loop_en = (t.loop_cycles != 0 && r <= t.loop_cycles);
      len     = (r == 0) ? ADDR_W'(t.len) : ADDR_W'($urandom);
      @(negedge clk);
      if (out_valid) begin got_d.push_back(out_data); got_c.push_back(r); end
      if (busy) busy_cnt++;
      if (r == 1) chk("err_after_start", err, t.exp_err);
      if (done) begin ndone++; if (done_r < 0) done_r = r; end
      if (done_r >= 0 && r == done_r + 1) chk("busy_after_done", busy, 0);
      if ((done_r >= 0 && r == done_r + 4) || (t.len == 0 && r == 12)) break;
    end
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;

    chk("done_count", ndone, t.exp_done);
    exp_n = (t.exp_n < 0) ? exp_q.size()
                          : t.exp_n + ((run_end > 0 && !stopped) ? FLUSH_N : 0);
    chk("out_count", got_d.size(), exp_n);
    for (int j = 0; j < got_d.size() && j < exp_q.size(); j++) begin
      if (bad_idx < 0 && (got_d[j] !== exp_q[j] || got_c[j] != FIR_LAT + 3 + j)) begin
        bad_idx = j;
        $display("  output %0d: data %h at cycle %0d, want %h at cycle %0d",
                 j, got_d[j], got_c[j], exp_q[j], FIR_LAT + 3 + j);
      end
    end
    chk("out_stream_first_bad", bad_idx, -1);
    if (t.exp_done) begin
      exp_done_r = (exp_q.size() > 0) ? FIR_LAT + 3 + exp_q.size() : run_end + 2;
      chk("done_cycle", done_r, exp_done_r);
    end
    if (t.len == 0) chk("busy_never", busy_cnt, 0);
    chk("err_end", err, t.exp_err);
    chk("fir_din_idle", fir_din, 0);
  endtask

  scn_t tbl[10];
  scn_t rs;
  int   extra;

  initial begin
    //          len  loop stop drn ramp exp_n err done
    tbl[0] = '{   4,   0,   0, 0,  1,    4,  0,  1};
    tbl[1] = '{   3,  10,   0, 0,  0,   12,  0,  1};
    tbl[2] = '{  50,   0,   3, 1,  0,    2,  0,  1};
    tbl[3] = '{   0,   0,   0, 0,  0,    0,  1,  0};
    tbl[4] = '{ 200,   0,   0, 0,  0,  100,  0,  1};
    tbl[5] = '{   1,   0,   0, 0,  0,    1,  0,  1};
    tbl[6] = '{ 101,   0,   0, 0,  0,  100,  0,  1};
    tbl[7] = '{  99,   0,   0, 0,  0,   99,  0,  1};
    tbl[8] = '{   2,   0,   1, 1,  0,    0,  0,  1};
    tbl[9] = '{   5,  10,   5, 0,  0,    4,  0,  1};

    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; len = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fir_din", fir_din, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    foreach (tbl[i]) run_scn(tbl[i]);

    for (int k = 0; k < 8; k++) begin
      rs.len         = $urandom_range(0, 110);
      rs.loop_cycles = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 150) : 0;
      rs.stop_at     = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 120) : 0;
      rs.drain_start = 1'($urandom_range(0, 1));
      rs.ramp        = 1'b0;
      rs.exp_n       = -1;
      rs.exp_err     = (rs.len == 0);
      rs.exp_done    = (rs.len != 0);
      run_scn(rs);
    end

    // Reset in the middle of RUN.
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom) | 16'h1;
    @(posedge clk); #1; start = 1'b1; len = 8'd50;
    repeat (6) begin @(posedge clk); #1; start = 1'b0; end
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_fir_din", fir_din, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || done || busy) extra++;
    end
    chk("midrst_quiet", extra, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_stream_ctrl.md
Name: fir_stream_ctrl

Overview:
Playback sequencer for the 16-bit FIR filter. It walks a synchronous-read sample memory from address 0 to len-1, drives the filter's data_in, and re-times the filter's data_out into a valid-qualified output stream. It supports one-shot and looping playback, an abort request, and busy/done status. It sits between the sample RAM and the FIR datapath, replacing ad-hoc address counters.

Parameters:
DATA_W, 16, sample width (filter input and output).
DEPTH, 100, sample memory depth.
ADDR_W, 7, address width; must satisfy 2**ADDR_W >= DEPTH.
FIR_LAT, 1, filter latency in clocks from data_in to the matching data_out (minimum 1).
FLUSH_LEN, 16, number of zero samples fed during flush (used only with the optional feature).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request; honoured only in IDLE
stop  in  1  abort request; honoured in RUN
loop_en  in  1  when 1, wrap to address 0 after len-1 instead of finishing
len  in  ADDR_W  sample count, latched at start
mem_addr  out  ADDR_W  sample memory read address
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr
fir_din  out  DATA_W  drives FIR data_in
fir_dout  in  DATA_W  FIR data_out
out_data  out  DATA_W  captured filter output
out_valid  out  1  out_data holds a sample-aligned result this cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when playback completes or is aborted
err  out  1  sticky; set when start arrives with len==0; cleared by reset or by the next accepted start

Behaviour:
- Reset values: mem_addr=0, fir_din=0, out_data=0, out_valid=0, busy=0, done=0, err=0, state=IDLE. All pipeline valid bits are cleared.
- Reset mid-operation aborts immediately. No done pulse is produced.
- States and transitions:
  - IDLE: on start with len!=0, latch len_q = min(len, DEPTH) and go to RUN. On start with len==0, set err and stay in IDLE.
  - RUN: issue one address per cycle, mem_addr = 0,1,…,len_q-1.
    - At the last address with loop_en=1, the next address is 0 with no bubble.
    - At the last address with loop_en=0, go to DRAIN after that cycle.
    - When stop=1 in RUN, the current cycle's address is not issued and the state goes to DRAIN. stop takes priority over wrap.
  - DRAIN: no new addresses. Stay until all in-flight valid bits (2+FIR_LAT stages) are clear, then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- start is ignored when the state is not IDLE. loop_en is sampled every RUN cycle, so clearing it ends playback at the next len_q-1.
- Pipeline: address k issued in cycle c gives
  - fir_din = RAM[k] registered at cycle c+2;
  - out_data = fir_dout captured with out_valid=1 at cycle c+2+FIR_LAT.
- fir_din is driven to 0 whenever its stage is not valid, so the filter only sees zeros between bursts.
- mem_addr holds its last value when not issuing.
- First-output latency from start: FIR_LAT+3 cycles. Throughput: 1 sample per clock in RUN.

Optional Feature:
- Macro: FIR_STREAM_FLUSH_EN.
- When defined: DRAIN begins with a FLUSH sub-phase that injects FLUSH_LEN zero samples as valid fir_din, producing FLUSH_LEN additional out_valid results (the filter tail). The wait for the pipeline to empty follows. Flush is skipped when exiting RUN via stop.
- When undefined: no flush logic is built. Output count equals the number of issued samples.

Decomposition:
- Package fir_stream_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE} plus FLUSH under the macro;
  - DATA_W/ADDR_W defaults;
  - PIPE_STAGES = 2+FIR_LAT localparam function.
- Sub-module fir_valid_delay: parameterised shift register of valid bits (length FIR_LAT), with synchronous clear. It produces the out_valid capture enable and the "pipeline empty" flag.

Test Plan:
- One-shot, len=4, RAM[i]=i+1, FIR_LAT=1, identity FIR model: mem_addr 0..3 in consecutive cycles, fir_din 1,2,3,4, exactly 4 out_valid pulses with out_data 1..4. done pulses once, 4 cycles after the last address; busy falls the cycle after done.
- Loop, len=3, loop_en held for 10 RUN cycles: addresses 0,1,2,0,1,2,… with no bubble at the wrap. Dropping loop_en mid-pass ends after address 2.
- stop asserted on the 3rd RUN cycle with len=50: only addresses 0,1 are issued, 2 outputs are produced, done is asserted. A start pulse during DRAIN is ignored.
- start with len=0: err=1 and busy stays 0. A following start with len=200 is clamped to 100 addresses and clears err.
- Reset asserted mid-RUN: next cycle all outputs are at reset values, with no done pulse and no further out_valid.
- With FIR_STREAM_FLUSH_EN, len=2, FLUSH_LEN=16: exactly 18 out_valid pulses, the last 16 driven by zero inputs. With stop, exactly as many outputs as issued samples.
